addr_seq: RTL and testbench



---
 rtl/addr_seq_pkg.sv | 42 ++++
 rtl/addr_seq_idx_add.sv | 18 +
 rtl/addr_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_addr_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// addr_seq_pkg: addressing-mode codes, FSM state encoding and small
// mode-decode helpers shared by the effective-address sequencer.
package addr_seq_pkg;

  // 4-bit addressing mode codes presented on addr_seq.mode
  localparam logic [3:0] IMM   = 4'd0;
  localparam logic [3:0] ZP    = 4'd1;
  localparam logic [3:0] ZP_X  = 4'd2;
  localparam logic [3:0] ZP_Y  = 4'd3;
  localparam logic [3:0] ABS   = 4'd4;
  localparam logic [3:0] ABS_X = 4'd5;
  localparam logic [3:0] ABS_Y = 4'd6;
  localparam logic [3:0] IND_X = 4'd7;
  localparam logic [3:0] IND_Y = 4'd8;
  localparam logic [3:0] IND   = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OP_LO  = 3'd1,
    S_OP_HI  = 3'd2,
    S_INDEX  = 3'd3,
    S_PTR_LO = 3'd4,
    S_PTR_HI = 3'd5,
    S_FIXUP  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // Modes indexed by Y rather than X
  function automatic logic uses_y(input logic [3:0] m);
    return (m == ZP_Y) || (m == ABS_Y) || (m == IND_Y);
  endfunction

  // Operand bytes consumed by the instruction
  function automatic logic [1:0] adv_of(input logic [3:0] m);
    return ((m == ABS) || (m == ABS_X) || (m == ABS_Y) || (m == IND)) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic mode_known(input logic [3:0] m);
    return m <= IND;
  endfunction

endpackage

// File: rtl/addr_seq_idx_add.sv
// idx_add: W-bit adder with carry-in and carry-out.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (mod 2^W)
//   cout : carry out of the top bit
module idx_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/addr_seq.sv
// addr_seq: multi-cycle effective-address sequencer for the 6502-style core.
// Fetches operand / pointer bytes over a ready-handshaked read port and
// returns the effective address, operand byte count and page-cross flag.
//   CLK, R              : clock, async active-low reset
//   start/mode/is_write : request (sampled in IDLE only)
//   pc_in/idx_x/idx_y   : operand address and index registers, captured on start
//   mem_req/mem_addr    : read request and address (held while mem_rdy=0)
//   mem_rdy/mem_rdata   : read completion and data
//   busy/done           : in-flight flag, one-cycle completion pulse
//   ea/pc_adv/page_cross: result, held until the next accepted start
module addr_seq
  import addr_seq_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 16,
  parameter int PAGE_PENALTY = 1,
  parameter int JMP_IND_BUG  = 1
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] idx_x,
  input  logic [DATA_W-1:0] idx_y,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ea,
  output logic [1:0]        pc_adv,
  output logic              page_cross
);

  state_t            state, state_n;
  logic [3:0]        mode_r;
  logic              wr_r;
  logic [DATA_W-1:0] idx_r;
  logic [DATA_W-1:0] base_lo, base_lo_n;
  logic [ADDR_W-1:0] res_ea, res_ea_n;
  logic              res_cr, res_cr_n;
  logic [ADDR_W-1:0] maddr_n, ea_n;
  logic [1:0]        adv_n;
  logic              cr_n;

  function automatic logic [ADDR_W-1:0] zpg(input logic [DATA_W-1:0] b);
    return {{(ADDR_W-DATA_W){1'b0}}, b};
  endfunction

  // Index add: base_lo + idx; the high byte comes straight off the read bus
  // so ABS_X/Y and IND_Y finish in the cycle the last byte arrives.
  logic [DATA_W-1:0] lo_sum, hi_sum;
  logic              lo_co, unused_hi_co;

  idx_add #(.W(DATA_W)) u_lo (
    .a(base_lo), .b(idx_r), .cin(1'b0), .sum(lo_sum), .cout(lo_co));
  idx_add #(.W(DATA_W)) u_hi (
    .a(mem_rdata), .b({DATA_W{1'b0}}), .cin(lo_co), .sum(hi_sum), .cout(unused_hi_co));

  // Address increment of the current mem_addr. The carry into the high byte
  // is kept for the operand fetch and for IND without the page-wrap quirk;
  // zero-page pointers always wrap inside page 0.
  logic [DATA_W-1:0] inc_lo, inc_hi;
  logic              inc_co, unused_inc_co, full_inc;

  assign full_inc = (state == S_OP_LO) || ((mode_r == IND) && (JMP_IND_BUG == 0));

  idx_add #(.W(DATA_W)) u_inc_lo (
    .a(mem_addr[DATA_W-1:0]), .b({DATA_W{1'b0}}), .cin(1'b1), .sum(inc_lo), .cout(inc_co));
  idx_add #(.W(DATA_W)) u_inc_hi (
    .a(mem_addr[ADDR_W-1:DATA_W]), .b({DATA_W{1'b0}}), .cin(inc_co & full_inc),
    .sum(inc_hi), .cout(unused_inc_co));

  logic [ADDR_W-1:0] idx_ea;
  logic              fix_req;

  assign idx_ea  = {hi_sum, lo_sum};
  assign fix_req = (lo_co && (PAGE_PENALTY != 0)) || wr_r;

  always_comb begin
    state_n   = state;
    maddr_n   = mem_addr;
    base_lo_n = base_lo;
    res_ea_n  = res_ea;
    res_cr_n  = res_cr;
    ea_n      = ea;
    adv_n     = pc_adv;
    cr_n      = page_cross;
    case (state)
      S_IDLE: if (start) begin
        if ((mode == IMM) || !mode_known(mode)) begin
          state_n = S_DONE;
          ea_n    = pc_in;
          adv_n   = 2'd1;
          cr_n    = 1'b0;
        end else begin
          state_n = S_OP_LO;
          maddr_n = pc_in;
        end
      end
      S_OP_LO: if (mem_rdy) begin
        case (mode_r)
          ZP: begin
            state_n = S_DONE;
            ea_n    = zpg(mem_rdata);
            adv_n   = adv_of(mode_r);
            cr_n    = 1'b0;
          end
          ZP_X, ZP_Y, IND_X: begin
            base_lo_n = mem_rdata;
            state_n   = S_INDEX;
          end
          IND_Y: begin
            maddr_n = zpg(mem_rdata);
            state_n = S_PTR_LO;
          end
          default: begin
            base_lo_n = mem_rdata;
            maddr_n   = {inc_hi, inc_lo};
            state_n   = S_OP_HI;
          end
        endcase
      end
      S_OP_HI: if (mem_rdy) begin
        if (mode_r == IND) begin
          maddr_n = {mem_rdata, base_lo};
          state_n = S_PTR_LO;
        end else if ((mode_r == ABS_X) || (mode_r == ABS_Y)) begin
          res_ea_n = idx_ea;
          res_cr_n = lo_co;
          if (fix_req) state_n = S_FIXUP;
          else begin
            state_n = S_DONE;
            ea_n    = idx_ea;
            adv_n   = adv_of(mode_r);
            cr_n    = lo_co;
          end
        end else begin
          state_n = S_DONE;
          ea_n    = {mem_rdata, base_lo};
          adv_n   = adv_of(mode_r);
          cr_n    = 1'b0;
        end
      end
      S_INDEX: begin
        if (mode_r == IND_X) begin
          maddr_n = zpg(lo_sum);
          state_n = S_PTR_LO;
        end else begin
          state_n = S_DONE;
          ea_n    = zpg(lo_sum);
          adv_n   = adv_of(mode_r);
          cr_n    = 1'b0;
        end
      end
      S_PTR_LO: if (mem_rdy) begin
        base_lo_n = mem_rdata;
        maddr_n   = {inc_hi, inc_lo};
        state_n   = S_PTR_HI;
      end
      S_PTR_HI: if (mem_rdy) begin
        if (mode_r == IND_Y) begin
          res_ea_n = idx_ea;
          res_cr_n = lo_co;
          if (fix_req) state_n = S_FIXUP;
          else begin
            state_n = S_DONE;
            ea_n    = idx_ea;
            adv_n   = adv_of(mode_r);
            cr_n    = lo_co;
          end
        end else begin
          state_n = S_DONE;
          ea_n    = {mem_rdata, base_lo};
          adv_n   = adv_of(mode_r);
          cr_n    = 1'b0;
        end
      end
      S_FIXUP: begin
        state_n = S_DONE;
        ea_n    = res_ea;
        adv_n   = adv_of(mode_r);
        cr_n    = res_cr;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state      <= S_IDLE;
      mode_r     <= 4'd0;
      wr_r       <= 1'b0;
      idx_r      <= '0;
      base_lo    <= '0;
      res_ea     <= '0;
      res_cr     <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ea         <= '0;
      pc_adv     <= 2'd0;
      page_cross <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        mode_r <= mode;
        wr_r   <= is_write;
        idx_r  <= uses_y(mode) ? idx_y : idx_x;
      end
      state      <= state_n;
      base_lo    <= base_lo_n;
      res_ea     <= res_ea_n;
      res_cr     <= res_cr_n;
      mem_addr   <= maddr_n;
      mem_req    <= (state_n == S_OP_LO) || (state_n == S_OP_HI) ||
                    (state_n == S_PTR_LO) || (state_n == S_PTR_HI);
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
      ea         <= ea_n;
      pc_adv     <= adv_n;
      page_cross <= cr_n;
    end
  end

endmodule

// File: tb/tb_addr_seq.sv
// tb_addr_seq: scoreboard bench for addr_seq. Three instances share clock and
// reset: u_a (defaults), u_b (no page penalty, no IND page wrap) driven by the
// same stimulus, and u_c (4-bit data, 8-bit address) driven separately.
module tb_addr_seq;
  import addr_seq_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        R, start, is_write, mem_rdy;
  logic [3:0]  mode;
  logic [15:0] pc_in;
  logic [7:0]  idx_x, idx_y;

  logic        mem_req_a, busy_a, done_a, page_cross_a;
  logic [15:0] mem_addr_a, ea_a;
  logic [7:0]  mem_rdata_a;
  logic [1:0]  pc_adv_a;
  logic        mem_req_b, busy_b, done_b, page_cross_b;
  logic [15:0] mem_addr_b, ea_b;
  logic [7:0]  mem_rdata_b;
  logic [1:0]  pc_adv_b;

  logic        start_c, mem_req_c, busy_c, done_c, page_cross_c;
  logic [7:0]  pc_c, mem_addr_c, ea_c;
  logic [3:0]  x_c, y_c, mem_rdata_c;
  logic [1:0]  pc_adv_c;

  logic [7:0] mem   [0:65535];
  logic [3:0] mem_c [0:255];

  assign mem_rdata_a = mem[mem_addr_a];
  assign mem_rdata_b = mem[mem_addr_b];
  assign mem_rdata_c = mem_c[mem_addr_c];

  addr_seq u_a (
    .CLK(CLK), .R(R), .start(start), .mode(mode), .is_write(is_write),
    .pc_in(pc_in), .idx_x(idx_x), .idx_y(idx_y),
    .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata_a),
    .busy(busy_a), .done(done_a), .ea(ea_a), .pc_adv(pc_adv_a), .page_cross(page_cross_a));

  addr_seq #(.PAGE_PENALTY(0), .JMP_IND_BUG(0)) u_b (
    .CLK(CLK), .R(R), .start(start), .mode(mode), .is_write(is_write),
    .pc_in(pc_in), .idx_x(idx_x), .idx_y(idx_y),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata_b),
    .busy(busy_b), .done(done_b), .ea(ea_b), .pc_adv(pc_adv_b), .page_cross(page_cross_b));

  addr_seq #(.DATA_W(4), .ADDR_W(8)) u_c (
    .CLK(CLK), .R(R), .start(start_c), .mode(mode), .is_write(is_write),
    .pc_in(pc_c), .idx_x(x_c), .idx_y(y_c),
    .mem_req(mem_req_c), .mem_addr(mem_addr_c), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata_c),
    .busy(busy_c), .done(done_c), .ea(ea_c), .pc_adv(pc_adv_c), .page_cross(page_cross_c));

  typedef struct {
    logic [15:0] ea;
    logic [1:0]  adv;
    logic        cr;
    int          t0;
    int          lat;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int checks = 0, failures = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] e, input logic [1:0] adv, input logic cr,
                              input int lat);
    exp_t x;
    x.ea = e; x.adv = adv; x.cr = cr; x.t0 = cyc; x.lat = lat;
    return x;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [15:0] a_ea,
                     input logic [1:0] a_adv, input logic a_cr);
    chk({tag, " ea"}, a_ea, e.ea);
    chk({tag, " pc_adv"}, a_adv, e.adv);
    chk({tag, " page_cross"}, a_cr, e.cr);
    chk({tag, " latency"}, cyc - e.t0, e.lat);
  endtask

  // Monitors: every done pulse pops one expected result
  always @(negedge CLK) if (done_a) begin
    if (qa.size() == 0) begin
      checks++; failures++;
      $display("FAIL a unexpected done actual=1 required=0");
    end else cmp("a", qa.pop_front(), ea_a, pc_adv_a, page_cross_a);
  end
  always @(negedge CLK) if (done_b) begin
    if (qb.size() == 0) begin
      checks++; failures++;
      $display("FAIL b unexpected done actual=1 required=0");
    end else cmp("b", qb.pop_front(), ea_b, pc_adv_b, page_cross_b);
  end
  always @(negedge CLK) if (done_c) begin
    if (qc.size() == 0) begin
      checks++; failures++;
      $display("FAIL c unexpected done actual=1 required=0");
    end else cmp("c", qc.pop_front(), {8'h00, ea_c}, pc_adv_c, page_cross_c);
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (!busy_a && !busy_b && !busy_c) begin ok = 1'b1; break; end
    end
    chk("idle reached", ok, 1);
    chk("a pending", qa.size(), 0);
    chk("b pending", qb.size(), 0);
    chk("c pending", qc.size(), 0);
  endtask

  task automatic run(input logic [3:0] m, input logic w, input logic [15:0] pc,
                     input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] ea_ea, input logic [15:0] ea_eb,
                     input logic [1:0] adv, input logic cr, input int la, input int lb);
    @(negedge CLK);
    mode = m; is_write = w; pc_in = pc; idx_x = x; idx_y = y; start = 1'b1;
    qa.push_back(mk(ea_ea, adv, cr, la));
    qb.push_back(mk(ea_eb, adv, cr, lb));
    @(negedge CLK);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic run_c(input logic [3:0] m, input logic [7:0] pc, input logic [3:0] x,
                       input logic [7:0] e, input logic [1:0] adv, input logic cr,
                       input int lat);
    @(negedge CLK);
    mode = m; is_write = 1'b0; pc_c = pc; x_c = x; y_c = 4'h0; start_c = 1'b1;
    qc.push_back(mk({8'h00, e}, adv, cr, lat));
    @(negedge CLK);
    start_c = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem_c[i] = 4'h0;
    mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12;   // ABS_X
    mem[16'h0210] = 8'hF0;                          // ZP_X
    mem[16'h0220] = 8'h00; mem[16'h0221] = 8'h12;   // ABS_Y
    mem[16'h0230] = 8'hFF;                          // IND_Y pointer
    mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12; mem[16'h0100] = 8'h99;
    mem[16'h0240] = 8'hFF; mem[16'h0241] = 8'h10;   // IND pointer $10FF
    mem[16'h10FF] = 8'hCD; mem[16'h1000] = 8'hAB; mem[16'h1100] = 8'hEF;
    mem[16'h0260] = 8'h42;                          // ZP
    mem[16'h0280] = 8'h34; mem[16'h0281] = 8'h12;   // ABS
    mem[16'hFFFF] = 8'h11;                          // ABS operand wrap
    mem[16'h0290] = 8'h20;                          // IND_X
    mem[16'h0024] = 8'h78; mem[16'h0025] = 8'h56;
    mem_c[8'h10] = 4'h8; mem_c[8'h11] = 4'hF;
    mem_c[8'h20] = 4'hF;

    R = 1'b0; start = 1'b0; start_c = 1'b0; is_write = 1'b0; mem_rdy = 1'b1;
    mode = 4'd0; pc_in = 16'h0; idx_x = 8'h0; idx_y = 8'h0;
    pc_c = 8'h0; x_c = 4'h0; y_c = 4'h0;

    repeat (3) @(negedge CLK);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst mem_req", mem_req_a, 0);
    chk("rst mem_addr", mem_addr_a, 0);
    chk("rst ea", ea_a, 0);
    chk("rst pc_adv", pc_adv_a, 0);
    chk("rst page_cross", page_cross_a, 0);
    chk("rst c busy", busy_c, 0);
    R = 1'b1;
    repeat (2) @(negedge CLK);

    //   mode   wr    pc        X      Y      ea(a)     ea(b)    adv  cr  lat a,b
    run(ABS_X, 1'b0, 16'h0200, 8'h20, 8'h00, 16'h1310, 16'h1310, 2'd2, 1'b1, 4, 3);
    run(ZP_X,  1'b0, 16'h0210, 8'h20, 8'h00, 16'h0010, 16'h0010, 2'd1, 1'b0, 3, 3);
    run(ABS_Y, 1'b1, 16'h0220, 8'h00, 8'h05, 16'h1205, 16'h1205, 2'd2, 1'b0, 4, 4);
    run(ABS_Y, 1'b0, 16'h0220, 8'h00, 8'h05, 16'h1205, 16'h1205, 2'd2, 1'b0, 3, 3);
    run(IND_Y, 1'b0, 16'h0230, 8'h00, 8'h10, 16'h1244, 16'h1244, 2'd1, 1'b0, 4, 4);
    run(IND_Y, 1'b0, 16'h0230, 8'h00, 8'hD0, 16'h1304, 16'h1304, 2'd1, 1'b1, 5, 4);
    run(IND,   1'b0, 16'h0240, 8'h00, 8'h00, 16'hABCD, 16'hEFCD, 2'd2, 1'b0, 5, 5);
    run(IMM,   1'b0, 16'h0250, 8'h00, 8'h00, 16'h0250, 16'h0250, 2'd1, 1'b0, 1, 1);
    run(ZP,    1'b0, 16'h0260, 8'h00, 8'h00, 16'h0042, 16'h0042, 2'd1, 1'b0, 2, 2);
    run(4'hC,  1'b0, 16'h0270, 8'h00, 8'h00, 16'h0270, 16'h0270, 2'd1, 1'b0, 1, 1);
    run(ABS,   1'b0, 16'h0280, 8'h00, 8'h00, 16'h1234, 16'h1234, 2'd2, 1'b0, 3, 3);
    run(ABS,   1'b0, 16'hFFFF, 8'h00, 8'h00, 16'h1211, 16'h1211, 2'd2, 1'b0, 3, 3);

    // IND_X with a 3-cycle stall in PTR_LO; start pulses while busy and in DONE
    @(negedge CLK);
    mode = IND_X; is_write = 1'b0; pc_in = 16'h0290; idx_x = 8'h04; idx_y = 8'h00;
    start = 1'b1;
    qa.push_back(mk(16'h5678, 2'd1, 1'b0, 8));
    qb.push_back(mk(16'h5678, 2'd1, 1'b0, 8));
    @(negedge CLK);
    start = 1'b0;
    mode = ZP;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("stall mem_req", mem_req_a, 1);
      chk("stall mem_addr", mem_addr_a, 16'h0024);
      mem_rdy = (k == 3);
      start = (k == 1);
    end
    @(negedge CLK);
    chk("ptr_hi mem_addr", mem_addr_a, 16'h0025);
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle();

    // Reset during PTR_HI aborts with no done
    @(negedge CLK);
    mode = IND_X; pc_in = 16'h0290; idx_x = 8'h04; start = 1'b1;
    qa.push_back(mk(16'h5678, 2'd1, 1'b0, 5));
    qb.push_back(mk(16'h5678, 2'd1, 1'b0, 5));
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre-reset mem_req", mem_req_a, 1);
    chk("pre-reset mem_addr", mem_addr_a, 16'h0025);
    R = 1'b0;
    qa.delete(); qb.delete();
    #1;
    chk("abort busy", busy_a, 0);
    chk("abort mem_req", mem_req_a, 0);
    chk("abort done", done_a, 0);
    chk("abort b busy", busy_b, 0);
    chk("abort b mem_req", mem_req_b, 0);
    repeat (2) @(negedge CLK);
    R = 1'b1;
    repeat (3) @(negedge CLK);
    run(ZP, 1'b0, 16'h0260, 8'h00, 8'h00, 16'h0042, 16'h0042, 2'd1, 1'b0, 2, 2);

    // Narrow instance: 4-bit data, 8-bit address
    run_c(ABS_X, 8'h10, 4'h9, 8'h01, 2'd2, 1'b1, 4);
    run_c(ZP_X,  8'h20, 4'h3, 8'h02, 2'd1, 1'b0, 3);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
